cpu_multicycle: RTL and testbench
=================================

# cpu_multicycle

Parametrised multicycle accumulator-free CPU core that runs the full team ISA from a single-port synchronous memory: MOV (short and immediate), ADD, SUB, MUL, DIV, IN, OUT and STOP, with direct and indirect operands. It replaces the fetch/decode-only core. It adds complete execution, valid/ready handshakes on the I/O channels and a generalised data/address width. It sits between the top-level memory block and the board I/O.

## Interface
- ADDR_WIDTH, 6, memory address width; indirect pointers use mem word bits [ADDR_WIDTH-1:0]
- DATA_WIDTH, 16, memory word and datapath width; must be >= 16
- PC_RESET, 8, program counter value after reset
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_in  in  DATA_WIDTH  read data, registered memory: value reflects mem[mem_addr] one cycle after mem_addr is presented
- mem_we  out  1  write enable, combinational from state; memory writes mem_data to mem_addr at the edge
- mem_addr  out  ADDR_WIDTH  registered (MAR)
- mem_data  out  DATA_WIDTH  registered (MDR)
- in  in  DATA_WIDTH  input channel data
- in_valid  in  1  input data available
- in_ready  out  1  core waiting for input (IN execute only)
- out  out  DATA_WIDTH  output channel data, registered, holds last OUT value
- out_valid  out  1  one-cycle pulse when out is updated
- pc, sp  out  ADDR_WIDTH  program counter; stack pointer (reserved, held at reset value)
- halted  out  1  high once STOP or an illegal opcode has executed

## Operation
- Instruction word (bits [15:0] of the memory word): opcode[15:12], A[11:8], B[7:4], C[3:0]. Operand field: bit 3 = indirect, bits 2:0 = register address 0..7 (memory locations 0..7).
- Direct operand value = mem[r]. Indirect operand value = mem[mem[r][ADDR_WIDTH-1:0]]. The same rule applies to the destination A.
- Opcodes:
  - 0 MOV: if C==4'b1000, two-word; second word is the immediate and A <= imm. Otherwise A <= B.
  - 1 ADD, 2 SUB, 3 MUL, 4 DIV: A <= B op C. Results are modulo 2^DATA_WIDTH. MUL keeps the low half. DIV is unsigned truncating; divide by zero gives 0.
  - 7 IN: A <= in.
  - 8 OUT: out <= value(A).
  - 15 STOP: halt.
  - 5, 6, 9–14: illegal, same as STOP.
- Fetch does mem_addr <= pc, pc <= pc+1. pc wraps modulo 2^ADDR_WIDTH. The immediate word increments pc again.
- States: FETCH_A, FETCH_W, FETCH_L (IR latch/decode), IMM_A/W/L, then per operand:
  - PTR_A/W/L (only if indirect)
  - RD_A/W/L
  - Order: dest pointer A, B, C.
- After operands: WR_SET (mem_addr <= dest, mem_data <= result), then WR (mem_we=1), then FETCH_A.
- IN path: IN_WAIT (in_ready=1). On in_valid&&in_ready, mem_data <= in, then WR. Waits indefinitely otherwise.
- OUT path: OUT (out <= operand, out_valid=1) -> FETCH_A.
- HALT: halted=1, no memory access, mem_we=0. pc is frozen at the address after STOP. Leaves only via rst_n.
- OUT and STOP never write memory. No write to locations other than the destination.

## Timing
- Reset (asynchronous, immediate):
  - pc=PC_RESET, sp=all ones
  - mem_addr=0, mem_data=0, mem_we=0
  - out=0, out_valid=0, in_ready=0, halted=0
  - IR=0, state=FETCH_A
  - First mem_addr=PC_RESET is visible one cycle after rst_n is released.
- Cycle costs:
  - Fetch: 3; immediate: 3.
  - Each operand read: 3 direct, 6 indirect.
  - Destination pointer (indirect A): 3.
  - Write: 2; OUT: 1; IN: 2 + wait cycles.
- Resulting totals, all-direct operands:
  - ADD = 11
  - MOV short = 8, MOV immediate = 8
  - OUT = 7
  - IN = 5 with in_valid already high
  - Each indirect operand adds 3.
- in_ready rises in the first IN_WAIT cycle and drops the cycle after the transfer.
- Reset mid-instruction aborts it. No write completes unless mem_we was high at an edge before reset.

## Test plan
- Reset, PC_RESET=8, mem[8]=MOV immediate to r1, mem[9]=0x1234 -> mem[1]=0x1234 after 8 cycles; pc=10.
- mem[1]=7, mem[2]=5; ADD r3,r1,r2 then SUB r4,r2,r1 -> mem[3]=12, mem[4]=0xFFFE. MUL 0x0100×0x0100 -> 0. DIV 7/0 -> 0.
- Indirect: mem[5]=0x20, mem[0x20]=9; OUT A=4'b1101 -> out=9, out_valid pulses once, 10 cycles after fetch start.
- IN r6 with in_valid held low 4 cycles, then in=0xBEEF -> in_ready high for exactly 5 cycles, mem[6]=0xBEEF, no write before the handshake.
- STOP at pc=0x3F -> halted=1, pc=0 (wrapped), mem_we stays 0 for 20 cycles. An illegal opcode 0x9 behaves identically.
- Assert rst_n low during an ADD in RD_W -> all outputs take their reset values immediately, destination unchanged, and fetch restarts at PC_RESET.

Source files
------------

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle memory-to-memory CPU core for the team ISA, running from a
// single-port registered memory, with valid/ready input and pulsed output channels.
module cpu_multicycle #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PC_RESET   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic                  halted
);

   typedef enum logic [4:0] {
      S_FETCH_A, S_FETCH_W, S_FETCH_L, S_IMM_A, S_IMM_W, S_IMM_L,
      S_PTR_A, S_PTR_W, S_PTR_L, S_RD_A, S_RD_W, S_RD_L,
      S_WR_SET, S_WR, S_IN_WAIT, S_OUT, S_HALT
   } state_t;

   localparam logic [3:0] OP_MOV = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4, OP_IN = 4'd7, OP_OUT = 4'd8;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, sp_q, sp_d, mem_addr_q, mem_addr_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, dest_q, dest_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d, out_q, out_d;
   logic [DATA_WIDTH-1:0] val_b_q, val_b_d, val_c_q, val_c_d;
   logic [15:0]           ir_q, ir_d;
   logic [1:0]            opnd_q, opnd_d;
   logic                  out_valid_q, out_valid_d, halted_q, halted_d;

   // Operand index 0/1/2 = field A/B/C; 3 means all operand accesses are done.
   function automatic logic [1:0] first_opnd(input logic [1:0] from, input logic [2:0] need);
      logic [1:0] r;
      r = 2'd3;
      if (from <= 2'd2 && need[2]) r = 2'd2;
      if (from <= 2'd1 && need[1]) r = 2'd1;
      if (from == 2'd0 && need[0]) r = 2'd0;
      return r;
   endfunction

   function automatic logic [3:0] sel_field(input logic [1:0] idx, input logic [15:0] w);
      case (idx)
         2'd0:    return w[11:8];
         2'd1:    return w[7:4];
         default: return w[3:0];
      endcase
   endfunction

   // During FETCH_L the word is still on mem_in; decode it directly so no cycle is lost.
   logic [15:0]     iw;
   logic [3:0]      op, fa, cur_field, nxt_field;
   logic            is_arith, is_imm, legal;
   logic [2:0]      need;
   logic [1:0]      start, nxt_opnd;
   state_t          done_state, nxt_state;
   logic [DATA_WIDTH-1:0] result;

   assign iw         = (state_q == S_FETCH_L) ? mem_in[15:0] : ir_q;
   assign op         = iw[15:12];
   assign fa         = iw[11:8];
   assign is_arith   = (op >= OP_ADD) && (op <= OP_DIV);
   assign is_imm     = (op == OP_MOV) && (iw[3:0] == 4'b1000);
   assign legal      = (op == OP_MOV) || is_arith || (op == OP_IN) || (op == OP_OUT);
   // A needs an access as a source for OUT, otherwise only as an indirect destination.
   assign need       = {is_arith, ((op == OP_MOV) && !is_imm) || is_arith, (op == OP_OUT) || fa[3]};
   assign start      = (state_q == S_FETCH_L || state_q == S_IMM_L) ? 2'd0 : opnd_q + 2'd1;
   assign nxt_opnd   = first_opnd(start, need);
   assign nxt_field  = sel_field(nxt_opnd, iw);
   assign cur_field  = sel_field(opnd_q, iw);
   assign done_state = (op == OP_IN) ? S_IN_WAIT : (op == OP_OUT) ? S_OUT : S_WR_SET;
   assign nxt_state  = (nxt_opnd == 2'd3) ? done_state : (nxt_field[3] ? S_PTR_A : S_RD_A);

   always_comb begin
      result = val_b_q;
      case (ir_q[15:12])
         OP_ADD:  result = val_b_q + val_c_q;
         OP_SUB:  result = val_b_q - val_c_q;
         OP_MUL:  result = val_b_q * val_c_q;
         OP_DIV:  result = (val_c_q == '0) ? '0 : val_b_q / val_c_q;
         default: result = val_b_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      ptr_d       = ptr_q;
      dest_d      = dest_q;
      val_b_d     = val_b_q;
      val_c_d     = val_c_q;
      ir_d        = ir_q;
      opnd_d      = opnd_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      halted_d    = halted_q;
      case (state_q)
         S_FETCH_A: begin
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDR_WIDTH'(1);
            state_d    = S_FETCH_W;
         end
         S_FETCH_W: state_d = S_FETCH_L;
         S_FETCH_L: begin
            ir_d   = mem_in[15:0];
            dest_d = ADDR_WIDTH'(mem_in[10:8]);
            if (!legal) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else if (is_imm) begin
               state_d = S_IMM_A;
            end else begin
               state_d = nxt_state;
               opnd_d  = nxt_opnd;
            end
         end
         S_IMM_A: begin
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDR_WIDTH'(1);
            state_d    = S_IMM_W;
         end
         S_IMM_W: state_d = S_IMM_L;
         S_IMM_L: begin
            val_b_d = mem_in;
            state_d = nxt_state;
            opnd_d  = nxt_opnd;
         end
         S_PTR_A: begin
            mem_addr_d = ADDR_WIDTH'(cur_field[2:0]);
            state_d    = S_PTR_W;
         end
         S_PTR_W: state_d = S_PTR_L;
         S_PTR_L: begin
            if (opnd_q == 2'd0 && op != OP_OUT) begin
               dest_d  = mem_in[ADDR_WIDTH-1:0];
               state_d = nxt_state;
               opnd_d  = nxt_opnd;
            end else begin
               ptr_d   = mem_in[ADDR_WIDTH-1:0];
               state_d = S_RD_A;
            end
         end
         S_RD_A: begin
            mem_addr_d = cur_field[3] ? ptr_q : ADDR_WIDTH'(cur_field[2:0]);
            state_d    = S_RD_W;
         end
         S_RD_W: state_d = S_RD_L;
         S_RD_L: begin
            case (opnd_q)
               2'd0: begin
                  out_d       = mem_in;
                  out_valid_d = 1'b1;
               end
               2'd1:    val_b_d = mem_in;
               default: val_c_d = mem_in;
            endcase
            state_d = nxt_state;
            opnd_d  = nxt_opnd;
         end
         S_WR_SET: begin
            mem_addr_d = dest_q;
            mem_data_d = result;
            state_d    = S_WR;
         end
         S_WR: state_d = S_FETCH_A;
         // Input handshake: a word transfers when in_valid && in_ready at a rising edge.
         // in_ready is high only in IN_WAIT; out_valid pulses once per new out value.
         S_IN_WAIT: begin
            if (in_valid) begin
               mem_data_d = in;
               mem_addr_d = dest_q;
               state_d    = S_WR;
            end
         end
         S_OUT:   state_d = S_FETCH_A;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH_A;
         pc_q        <= ADDR_WIDTH'(PC_RESET);
         sp_q        <= '1;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         ptr_q       <= '0;
         dest_q      <= '0;
         val_b_q     <= '0;
         val_c_q     <= '0;
         ir_q        <= '0;
         opnd_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         ptr_q       <= ptr_d;
         dest_q      <= dest_d;
         val_b_q     <= val_b_d;
         val_c_q     <= val_c_d;
         ir_q        <= ir_d;
         opnd_q      <= opnd_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   assign mem_we    = (state_q == S_WR);
   assign in_ready  = (state_q == S_IN_WAIT);
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign pc        = pc_q;
   assign sp        = sp_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs run on a registered single-port memory model,
// with hand-computed expected memory contents, pc values and cycle timing.
module tb_cpu_multicycle;
   localparam int AW = 6;
   localparam int DW = 16;

   // ---- clock / reset ----
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] mem_in;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [AW-1:0] pc, sp;
   logic          halted;

   cpu_multicycle #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_RESET(8)) dut (
      .clk(clk), .rst_n(rst_n), .mem_in(mem_in), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_data(mem_data), .in(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out(out_data), .out_valid(out_valid),
      .pc(pc), .sp(sp), .halted(halted)
   );

   // Memory model: registered read-first port plus a bench load port used during reset.
   logic [DW-1:0] mem [0:63];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   always @(posedge clk) begin
      mem_in <= mem[mem_addr];
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_we) mem[mem_addr] <= mem_data;
   end

   // Activity monitors and output scoreboard.
   int wr_cnt = 0;
   int wr_prog_cnt = 0;
   int in_ready_cyc = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   always @(posedge clk) begin
      if (mem_we) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_addr >= 6'd8) wr_prog_cnt <= wr_prog_cnt + 1;
      end
      if (in_ready) in_ready_cyc <= in_ready_cyc + 1;
      if (out_valid) got_q.push_back(out_data);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---- driver tasks ----
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int a, input logic [DW-1:0] d);
      ld_en   = 1'b1;
      ld_addr = AW'(a);
      ld_data = d;
      step(1);
      ld_en   = 1'b0;
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 64; a++) load(a, '0);
   endtask

   // Asserts reset mid-cycle and checks that every output clears without waiting for clk.
   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk({tag, "_pc"}, 32'(pc), 32'h8);
      chk({tag, "_sp"}, 32'(sp), 32'h3F);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
      chk({tag, "_mem_data"}, 32'(mem_data), 32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, "_out"}, 32'(out_data), 32'h0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      step(2);
   endtask

   logic [DW-1:0] term [2];
   int wr_base, ir_base;

   initial begin
      term[0] = 16'hF000;
      term[1] = 16'h9000;
      step(1);

      // MOV immediate: 8 cycles, pc advances past the immediate word
      do_reset("rst0");
      clear_mem();
      load(8, 16'h0108); load(9, 16'h1234); load(10, 16'hF000);
      rst_n = 1'b1;
      step(1);  chk("first_fetch_addr", 32'(mem_addr), 32'h8);
      step(6);  chk("movi_not_yet", 32'(mem[1]), 32'h0);
      step(1);  chk("movi_result", 32'(mem[1]), 32'h1234);
      chk("movi_pc", 32'(pc), 32'hA);
      step(1);  chk("movi_next_fetch", 32'(mem_addr), 32'hA);

      // Arithmetic: ADD, SUB wrap, MUL low half, DIV by zero
      do_reset("rst1");
      clear_mem();
      load(1, 16'd7); load(2, 16'd5); load(5, 16'h0100); load(6, 16'hAAAA);
      load(8, 16'h1312); load(9, 16'h2421); load(10, 16'h3555); load(11, 16'h4610);
      load(12, 16'hF000);
      wr_base = wr_cnt;
      rst_n = 1'b1;
      step(10); chk("add_not_yet", 32'(mem[3]), 32'h0);
      step(1);  chk("add_result", 32'(mem[3]), 32'hC);
      step(11); chk("sub_result", 32'(mem[4]), 32'hFFFE);
      step(11); chk("mul_result", 32'(mem[5]), 32'h0);
      step(11); chk("div0_result", 32'(mem[6]), 32'h0);
      step(2);  chk("arith_halt_early", 32'(halted), 32'h0);
      step(1);  chk("arith_halted", 32'(halted), 32'h1);
      chk("arith_pc", 32'(pc), 32'hD);
      chk("arith_writes", 32'(wr_cnt - wr_base), 32'd4);

      // Indirect OUT: 10 cycles, single out_valid pulse, no memory write
      do_reset("rst2");
      clear_mem();
      load(5, 16'h0020); load(32, 16'h0009); load(8, 16'h8D00); load(9, 16'hF000);
      exp_q.push_back(16'h0009);
      wr_base = wr_cnt;
      rst_n = 1'b1;
      step(8);  chk("out_valid_early", 32'(out_valid), 32'h0);
      step(1);  chk("out_valid_pulse", 32'(out_valid), 32'h1);
      chk("out_value", 32'(out_data), 32'h9);
      step(1);  chk("out_valid_drop", 32'(out_valid), 32'h0);
      chk("out_ind_addr", 32'(mem_addr), 32'h20);
      step(1);  chk("out_next_fetch", 32'(mem_addr), 32'h9);
      step(2);  chk("out_halted", 32'(halted), 32'h1);
      chk("out_hold", 32'(out_data), 32'h9);
      chk("out_no_write", 32'(wr_cnt - wr_base), 32'd0);

      // IN with in_valid held low for 4 wait cycles
      do_reset("rst3");
      clear_mem();
      load(8, 16'h7600); load(9, 16'hF000);
      wr_base = wr_cnt;
      ir_base = in_ready_cyc;
      in_data = 16'h1111;
      rst_n = 1'b1;
      step(3);  chk("in_ready_rise", 32'(in_ready), 32'h1);
      step(4);  chk("in_ready_wait", 32'(in_ready), 32'h1);
      chk("in_no_early_write", 32'(wr_cnt - wr_base), 32'd0);
      in_data  = 16'hBEEF;
      in_valid = 1'b1;
      step(1);  chk("in_ready_drop", 32'(in_ready), 32'h0);
      chk("in_we", 32'(mem_we), 32'h1);
      chk("in_mem_data", 32'(mem_data), 32'hBEEF);
      chk("in_mem_addr", 32'(mem_addr), 32'h6);
      in_valid = 1'b0;
      step(1);  chk("in_result", 32'(mem[6]), 32'hBEEF);
      chk("in_ready_cycles", 32'(in_ready_cyc - ir_base), 32'd5);
      chk("in_writes", 32'(wr_cnt - wr_base), 32'd1);

      // STOP and illegal opcode at 0x3F: pc wraps to 0, memory goes quiet
      for (int k = 0; k < 2; k++) begin
         do_reset("rst_halt");
         clear_mem();
         load(7, 16'h0042);
         for (int a = 8; a < 63; a++) load(a, 16'h0770);
         load(63, term[k]);
         wr_base = wr_cnt;
         ir_base = wr_prog_cnt;
         rst_n = 1'b1;
         step(442); chk("halt_early", 32'(halted), 32'h0);
         step(1);   chk("halt_set", 32'(halted), 32'h1);
         chk("halt_pc_wrap", 32'(pc), 32'h0);
         chk("halt_fill_writes", 32'(wr_cnt - wr_base), 32'd55);
         chk("halt_prog_untouched", 32'(wr_prog_cnt - ir_base), 32'd0);
         chk("halt_r7", 32'(mem[7]), 32'h42);
         step(20);  chk("halt_quiet_writes", 32'(wr_cnt - wr_base), 32'd55);
         chk("halt_pc_frozen", 32'(pc), 32'h0);
         chk("halt_stays", 32'(halted), 32'h1);
         chk("halt_mem_addr", 32'(mem_addr), 32'h3F);
         chk("halt_we", 32'(mem_we), 32'h0);
      end

      // Reset during ADD operand read: no write, fetch restarts at PC_RESET
      do_reset("rst4");
      clear_mem();
      load(1, 16'd7); load(2, 16'd5); load(3, 16'h5555);
      load(8, 16'h1312); load(9, 16'hF000);
      wr_base = wr_cnt;
      rst_n = 1'b1;
      step(4);  chk("abort_rd_addr", 32'(mem_addr), 32'h1);
      chk("abort_pc_before", 32'(pc), 32'h9);
      do_reset("rst_mid");
      chk("abort_dest_kept", 32'(mem[3]), 32'h5555);
      chk("abort_no_write", 32'(wr_cnt - wr_base), 32'd0);
      rst_n = 1'b1;
      step(1);  chk("abort_refetch", 32'(mem_addr), 32'h8);
      step(9);  chk("abort_rerun_early", 32'(mem[3]), 32'h5555);
      step(1);  chk("abort_rerun_add", 32'(mem[3]), 32'hC);

      // ---- final report ----
      chk("out_sb_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("out_sb_value", 32'(got_q[i]), 32'(exp_q[i]));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
